// File: rtl/input_event_scheduler_pkg.sv
// Shared types and constants for the gamepad input path.
//   interrupts_t : 4-bit event codes handed to the game FSM
//   BTN_*        : bit positions of each button on the raw button bus
//   rpt_state_t  : per-button auto-repeat timer states
//   code_of()    : button index -> event code (index + 1)
package tetris_input_pkg;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_SELECT = 4;
  localparam int BTN_START  = 5;
  localparam int BTN_A      = 6;
  localparam int BTN_B      = 7;

  typedef enum logic [3:0] {
    DO_NOTHING = 4'd0,
    MOVE_LEFT  = 4'd1,
    MOVE_RIGHT = 4'd2,
    MOVE_DOWN  = 4'd3,
    HARD_DROP  = 4'd4,
    HOLD_PIECE = 4'd5,
    PAUSE      = 4'd6,
    ROTATE_CW  = 4'd7,
    ROTATE_CCW = 4'd8
  } interrupts_t;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  function automatic interrupts_t code_of(input logic [2:0] idx);
    return interrupts_t'({1'b0, idx} + 4'd1);
  endfunction

endpackage

// File: rtl/input_event_scheduler_if.sv
// Event handshake between the input scheduler (master) and the game FSM (slave).
//   event_valid : event_code holds an unconsumed event
//   event_ready : consumer takes the event this cycle
//   event_code  : interrupt code, DO_NOTHING while event_valid is low
interface input_event_scheduler_if;
  import tetris_input_pkg::*;

  logic        event_valid;
  logic        event_ready;
  interrupts_t event_code;

  modport master (output event_valid, output event_code, input event_ready);
  modport slave  (input event_valid, input event_code, output event_ready);

endinterface

// File: rtl/input_event_scheduler_button_repeat_timer.sv
// Auto-repeat timer for one held button: first strobe DAS_CYCLES after the
// press, then one every ARR_CYCLES while the button stays held.
//   clk, rst_n    : clock, async active-low reset
//   held          : synchronised button level
//   press         : one-cycle press edge
//   enable        : scheduler enable; low forces the timer idle
//   repeat_strobe : one-cycle repeat request
//
// state      | meaning
// RPT_IDLE   | button released or disabled, counter cleared
// RPT_DELAY  | counting the initial hold delay
// RPT_REPEAT | counting between repeats
module button_repeat_timer
  import tetris_input_pkg::*;
#(
  parameter int DAS_CYCLES = 16,
  parameter int ARR_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic held,
  input  logic press,
  input  logic enable,
  output logic repeat_strobe
);

  localparam int MAX_CYCLES = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] DAS_LOAD = CW'(DAS_CYCLES - 1);
  localparam logic [CW-1:0] ARR_LOAD = CW'(ARR_CYCLES - 1);

  rpt_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RPT_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    repeat_strobe = 1'b0;
    // Release or disable aborts immediately, including a strobe due this cycle.
    if (!held || !enable) begin
      state_nxt = RPT_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RPT_IDLE: begin
          if (press) begin
            state_nxt = RPT_DELAY;
            cnt_nxt   = DAS_LOAD;
          end
        end
        RPT_DELAY, RPT_REPEAT: begin
          if (cnt == '0) begin
            repeat_strobe = 1'b1;
            state_nxt     = RPT_REPEAT;
            cnt_nxt       = ARR_LOAD;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        default: begin
          state_nxt = RPT_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_event_scheduler.sv
// Gamepad input scheduler: synchronises the button pins, turns press edges and
// auto-repeats into pending events, and hands them out one at a time in
// round-robin order.
//   clk, rst_n : clock, async active-low reset
//   enable     : accept new button events
//   buttons    : raw pins {b,a,start,select,up,down,right,left}
//   evt        : valid/ready event handshake (master side)
//   coalesced  : one-cycle pulse when an event merged into an already pending one
module input_event_scheduler
  import tetris_input_pkg::*;
#(
  parameter int         DAS_CYCLES  = 16,
  parameter int         ARR_CYCLES  = 4,
  parameter logic [7:0] REPEAT_MASK = 8'b0000_0111
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_BUTTONS-1:0]         buttons,
  input_event_scheduler_if.master        evt,
  output logic                           coalesced
);

  logic [NUM_BUTTONS-1:0] btn_meta, btn_s, btn_q;
  logic [NUM_BUTTONS-1:0] press, repeat_strobe, new_evt;
  logic [NUM_BUTTONS-1:0] pending, pending_nxt, req, grant;
  logic [2:0]             ptr, grant_idx, cand;
  logic                   grant_any, load, coalesced_nxt;

  assign press   = btn_s & ~btn_q;
  assign new_evt = {NUM_BUTTONS{enable}} & (press | repeat_strobe);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_rpt
    if (REPEAT_MASK[i]) begin : g_on
      button_repeat_timer #(
        .DAS_CYCLES (DAS_CYCLES),
        .ARR_CYCLES (ARR_CYCLES)
      ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .held          (btn_s[i]),
        .press         (press[i]),
        .enable        (enable),
        .repeat_strobe (repeat_strobe[i])
      );
    end else begin : g_off
      assign repeat_strobe[i] = 1'b0;
    end
  end

  // Round-robin pick: first requesting bit at or after ptr, wrapping at 8.
  always_comb begin
    req       = pending & {NUM_BUTTONS{enable}};
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_BUTTONS; k++) begin
      cand = ptr + 3'(k);
      if (!grant_any && req[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign load  = !evt.event_valid || evt.event_ready;
  assign grant = (load && grant_any) ? (NUM_BUTTONS'(1) << grant_idx) : '0;

  // A new event on the bit being granted re-arms it (set wins) and is not a merge.
  assign pending_nxt   = enable ? ((pending & ~grant) | new_evt) : '0;
  assign coalesced_nxt = |(new_evt & pending & ~grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta        <= '0;
      btn_s           <= '0;
      btn_q           <= '0;
      pending         <= '0;
      ptr             <= '0;
      coalesced       <= 1'b0;
      evt.event_valid <= 1'b0;
      evt.event_code  <= DO_NOTHING;
    end else begin
      btn_meta  <= buttons;
      btn_s     <= btn_meta;
      btn_q     <= btn_s;
      pending   <= pending_nxt;
      coalesced <= coalesced_nxt;
      if (load) begin
        if (grant_any) begin
          evt.event_valid <= 1'b1;
          evt.event_code  <= code_of(grant_idx);
          ptr             <= grant_idx + 3'd1;
        end else begin
          evt.event_valid <= 1'b0;
          evt.event_code  <= DO_NOTHING;
        end
      end
    end
  end

endmodule
